// File: rtl/button_repeat_ctrl.sv
// Set-button auto-repeat controller: turns debounced button levels into
// single-cycle increment strobes for the timekeeping core.
module button_repeat_ctrl #(
    parameter int CNT_W      = 12,
    parameter int HOLD_TICKS = 2048,
    parameter int SLOW_TICKS = 1024,
    parameter int FAST_TICKS = 256
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_tick_stb,
    input  logic i_set_hours_db,
    input  logic i_set_minutes_db,
    input  logic i_fast_set_db,
    output logic o_inc_hours,
    output logic o_inc_minutes,
    output logic o_setting
);
    // state     | meaning
    // IDLE      | no button active, waiting for a clean single press
    // HOLD_WAIT | one button held, counting ticks toward the first repeat
    // REPEAT    | auto-repeating at the slow or fast period
    // LOCKOUT   | both buttons seen together, wait until both released
    typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT, LOCKOUT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic             prev_h;
    logic             prev_m;
    logic             armed;

    logic             rise_h;
    logic             rise_m;
    logic             sel_lvl;
    logic             oth_rise;
    logic [CNT_W-1:0] due_last;
    logic [CNT_W-1:0] cnt_inc;

    assign rise_h   = i_set_hours_db & ~prev_h;
    assign rise_m   = i_set_minutes_db & ~prev_m;
    assign sel_lvl  = sel ? i_set_minutes_db : i_set_hours_db;
    assign oth_rise = sel ? rise_h : rise_m;
    assign due_last = (state == HOLD_WAIT) ? HOLD_LAST
                    : (i_fast_set_db ? FAST_LAST : SLOW_LAST);
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // armed stays low for the first cycle out of reset so prev_* can capture
    // the real levels; a button held through reset never counts as a press.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            sel           <= 1'b0;
            prev_h        <= 1'b0;
            prev_m        <= 1'b0;
            armed         <= 1'b0;
            o_inc_hours   <= 1'b0;
            o_inc_minutes <= 1'b0;
            o_setting     <= 1'b0;
        end else begin
            prev_h        <= i_set_hours_db;
            prev_m        <= i_set_minutes_db;
            armed         <= 1'b1;
            o_inc_hours   <= 1'b0;
            o_inc_minutes <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_set_hours_db && i_set_minutes_db) begin
                        state     <= LOCKOUT;
                        o_setting <= 1'b1;
                    end else if (armed && (rise_h || rise_m)) begin
                        sel           <= rise_m;
                        o_inc_hours   <= rise_h;
                        o_inc_minutes <= rise_m;
                        cnt           <= '0;
                        state         <= HOLD_WAIT;
                        o_setting     <= 1'b1;
                    end
                end
                HOLD_WAIT, REPEAT: begin
                    // release beats a same-cycle tick
                    if (!sel_lvl) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        o_setting <= 1'b0;
                    end else if (oth_rise) begin
                        state <= LOCKOUT;
                    end else if (i_tick_stb) begin
                        if (cnt >= due_last) begin
                            cnt           <= '0;
                            state         <= REPEAT;
                            o_inc_hours   <= ~sel;
                            o_inc_minutes <= sel;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                LOCKOUT: begin
                    if (!i_set_hours_db && !i_set_minutes_db) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        o_setting <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_setting <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Directed bench for button_repeat_ctrl with short hold/repeat periods and a
// tick every 4 clocks.
module tb_button_repeat_ctrl;
    logic i_clk;
    logic i_reset_n;
    logic i_tick_stb;
    logic i_set_hours_db;
    logic i_set_minutes_db;
    logic i_fast_set_db;
    logic o_inc_hours;
    logic o_inc_minutes;
    logic o_setting;

    int n_cmp = 0;
    int n_bad = 0;
    int n_h = 0;
    int n_m = 0;
    int both_seen = 0;
    int wide_seen = 0;
    int phase = 0;
    int base_h;
    int base_m;
    logic last_h = 1'b0;
    logic last_m = 1'b0;

    button_repeat_ctrl #(
        .CNT_W(4),
        .HOLD_TICKS(4),
        .SLOW_TICKS(3),
        .FAST_TICKS(2)
    ) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_tick_stb(i_tick_stb),
        .i_set_hours_db(i_set_hours_db),
        .i_set_minutes_db(i_set_minutes_db),
        .i_fast_set_db(i_fast_set_db),
        .o_inc_hours(o_inc_hours),
        .o_inc_minutes(o_inc_minutes),
        .o_setting(o_setting)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at the falling edge, then drive the tick.
    task automatic clk1();
        @(negedge i_clk);
        if (o_inc_hours === 1'b1) n_h++;
        if (o_inc_minutes === 1'b1) n_m++;
        if (o_inc_hours === 1'b1 && o_inc_minutes === 1'b1) both_seen++;
        if ((o_inc_hours === 1'b1 && last_h) || (o_inc_minutes === 1'b1 && last_m)) wide_seen++;
        last_h = (o_inc_hours === 1'b1);
        last_m = (o_inc_minutes === 1'b1);
        i_tick_stb = (phase == 3);
        phase = (phase + 1) % 4;
    endtask

    // Issue n ticks, then one more clock so the last tick's effect is visible.
    task automatic ticks(input int n);
        int seen = 0;
        int guard = 0;
        while (seen < n && guard < 1000) begin
            clk1();
            if (i_tick_stb) seen++;
            guard++;
        end
        clk1();
    endtask

    initial begin
        i_reset_n        = 1'b0;
        i_tick_stb       = 1'b0;
        i_set_hours_db   = 1'b1;
        i_set_minutes_db = 1'b0;
        i_fast_set_db    = 1'b0;

        // 1: reset with hours held, then release with hours still held
        repeat (3) clk1();
        chk("rst_inc_hours", 32'(o_inc_hours), 0);
        chk("rst_inc_minutes", 32'(o_inc_minutes), 0);
        chk("rst_setting", 32'(o_setting), 0);
        i_reset_n = 1'b1;
        repeat (6) clk1();
        chk("held_through_reset_no_strobe", n_h, 0);
        chk("held_through_reset_idle", 32'(o_setting), 0);
        i_set_hours_db = 1'b0;
        clk1();

        // 2: short press, released before the hold expires
        base_h = n_h;
        i_set_hours_db = 1'b1;
        clk1();
        chk("press_strobe", 32'(o_inc_hours), 1);
        chk("press_no_minutes", 32'(o_inc_minutes), 0);
        chk("press_setting", 32'(o_setting), 1);
        clk1();
        chk("press_strobe_one_cycle", 32'(o_inc_hours), 0);
        ticks(2);
        chk("short_press_count", n_h - base_h, 1);
        i_set_hours_db = 1'b0;
        clk1();
        chk("release_setting", 32'(o_setting), 0);

        // 3: minutes held, slow repeat
        base_h = n_h;
        base_m = n_m;
        i_set_minutes_db = 1'b1;
        ticks(3);
        chk("hold_before_tick4", n_m - base_m, 1);
        ticks(1);
        chk("hold_at_tick4", n_m - base_m, 2);
        ticks(2);
        chk("repeat_before_tick7", n_m - base_m, 2);
        ticks(1);
        chk("repeat_at_tick7", n_m - base_m, 3);
        ticks(9);
        chk("repeat_through_tick16", n_m - base_m, 6);
        chk("minutes_no_hours", n_h - base_h, 0);
        i_set_minutes_db = 1'b0;
        clk1();
        chk("minutes_release_setting", 32'(o_setting), 0);

        // 4: rate switches while repeating hours
        base_h = n_h;
        i_set_hours_db = 1'b1;
        ticks(4);
        chk("rate_enter_repeat", n_h - base_h, 2);
        i_fast_set_db = 1'b1;
        ticks(1);
        chk("fast_tick1_none", n_h - base_h, 2);
        ticks(1);
        chk("fast_tick2_strobe", n_h - base_h, 3);
        ticks(1);
        i_fast_set_db = 1'b0;
        ticks(1);
        chk("fast_to_slow_cnt2_none", n_h - base_h, 3);
        ticks(1);
        chk("fast_to_slow_next_tick", n_h - base_h, 4);
        ticks(2);
        chk("slow_cnt2_none", n_h - base_h, 4);
        i_fast_set_db = 1'b1;
        ticks(1);
        chk("slow_to_fast_no_wrap", n_h - base_h, 5);
        i_fast_set_db = 1'b0;
        i_set_hours_db = 1'b0;
        clk1();
        chk("rate_release_setting", 32'(o_setting), 0);

        // 5: second button during a hold locks out
        base_h = n_h;
        base_m = n_m;
        i_set_hours_db = 1'b1;
        ticks(1);
        i_set_minutes_db = 1'b1;
        ticks(6);
        chk("lockout_hours_count", n_h - base_h, 1);
        chk("lockout_minutes_count", n_m - base_m, 0);
        chk("lockout_setting", 32'(o_setting), 1);
        i_set_hours_db = 1'b0;
        ticks(3);
        chk("lockout_one_left_hours", n_h - base_h, 1);
        chk("lockout_one_left_minutes", n_m - base_m, 0);
        chk("lockout_one_left_setting", 32'(o_setting), 1);
        i_set_minutes_db = 1'b0;
        clk1();
        chk("lockout_exit_setting", 32'(o_setting), 0);
        i_set_minutes_db = 1'b1;
        clk1();
        chk("after_lockout_minutes", 32'(o_inc_minutes), 1);
        chk("after_lockout_no_hours", 32'(o_inc_hours), 0);
        i_set_minutes_db = 1'b0;
        clk1();
        chk("after_lockout_count", n_m - base_m, 1);

        // 6: release on the same cycle as a due repeat tick
        base_h = n_h;
        i_set_hours_db = 1'b1;
        ticks(4);
        ticks(2);
        for (int i = 0; i < 8; i++) begin
            clk1();
            if (i_tick_stb) break;
        end
        i_set_hours_db = 1'b0;
        clk1();
        chk("release_vs_tick_strobe", 32'(o_inc_hours), 0);
        chk("release_vs_tick_setting", 32'(o_setting), 0);
        ticks(2);
        chk("release_vs_tick_count", n_h - base_h, 2);

        // reset on the same edge as a press, button kept held afterwards
        base_h = n_h;
        i_set_hours_db = 1'b1;
        i_reset_n = 1'b0;
        clk1();
        chk("reset_vs_press_strobe", 32'(o_inc_hours), 0);
        chk("reset_vs_press_setting", 32'(o_setting), 0);
        i_reset_n = 1'b1;
        ticks(2);
        chk("reset_vs_press_count", n_h - base_h, 0);
        chk("reset_vs_press_idle", 32'(o_setting), 0);
        i_set_hours_db = 1'b0;
        clk1();

        chk("strobes_never_both", both_seen, 0);
        chk("strobes_one_cycle", wide_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
